// File: rtl/reg_file32.sv
// reg_file32: 32-entry general-purpose register file.
//
// Sits downstream of the write-enable decoder and feeds the ALU operand stage.
// Writes are selected by a one-hot enable vector. Bit 0 of that vector is
// ignored because r0 is hardwired to zero. A multi-hot enable over bits 31:1
// suppresses the write and raises a sticky error flag.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   WriteEn      in   32     one-hot write enable, bit i selects register i
//   WriteData    in   WIDTH  write data
//   ReadReg1     in   5      read port 1 address
//   ReadReg2     in   5      read port 2 address
//   ErrClr       in   1      synchronous clear of MultiHotErr
//   ReadData1    out  WIDTH  read port 1 data (combinational)
//   ReadData2    out  WIDTH  read port 2 data (combinational)
//   MultiHotErr  out  1      sticky multi-hot write-enable flag
//   WriteCount   out  16     committed writes since reset, saturating
//
// Parameters
//   WIDTH   register data width
//   BYPASS  1: a same-cycle one-hot write is forwarded to matching read ports
module reg_file32 #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      WriteEn,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             MultiHotErr,
  output logic [15:0]      WriteCount
);

  logic [30:0]      wr_vec;
  logic             wr_any;
  logic             wr_multi;
  logic             wr_onehot;

  logic [WIDTH-1:0] regs_q [32];
  logic             err_d, err_q;
  logic [15:0]      cnt_d, cnt_q;

  // Decode V = WriteEn[31:1].
  // v & (v - 1) is non-zero exactly when two or more bits of v are set.
  assign wr_vec    = WriteEn[31:1];
  assign wr_any    = |wr_vec;
  assign wr_multi  = |(wr_vec & (wr_vec - 31'd1));
  assign wr_onehot = wr_any & ~wr_multi;

  // Register storage.
  // Entry 0 is never written; reads of address 0 are forced to zero anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_onehot) begin
      for (int i = 1; i < 32; i++) begin
        if (wr_vec[i-1]) begin
          regs_q[i] <= WriteData;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_onehot && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Setting the flag takes priority over clearing it.
  always_comb begin
    err_d = err_q;
    if (wr_multi) begin
      err_d = 1'b1;
    end else if (ErrClr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Read ports.
  // Address 0 and an asserted reset both return zero. Reset gating also
  // stops the bypass path from leaking WriteData while reset is held.
  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    if (BYPASS && wr_onehot && WriteEn[ReadReg1]) begin
      ReadData1 = WriteData;
    end
    if (reset || (ReadReg1 == 5'd0)) begin
      ReadData1 = '0;
    end

    ReadData2 = regs_q[ReadReg2];
    if (BYPASS && wr_onehot && WriteEn[ReadReg2]) begin
      ReadData2 = WriteData;
    end
    if (reset || (ReadReg2 == 5'd0)) begin
      ReadData2 = '0;
    end
  end

  assign MultiHotErr = err_q;
  assign WriteCount  = cnt_q;

endmodule

// File: tb/tb_reg_file32.sv
// Testbench for reg_file32 (WIDTH=32, BYPASS=1).
// A behavioural model tracks register contents, the write count and the error
// flag. Expected read values are queued when stimulus is applied and popped
// when the outputs are sampled.
module tb_reg_file32;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   WriteEn;
  logic [W-1:0]  WriteData;
  logic [4:0]    ReadReg1;
  logic [4:0]    ReadReg2;
  logic          ErrClr;
  logic [W-1:0]  ReadData1;
  logic [W-1:0]  ReadData2;
  logic          MultiHotErr;
  logic [15:0]   WriteCount;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0]  m_regs [32];
  logic [15:0]   m_cnt;
  logic          m_err;
  logic [W-1:0]  exp_q [$];

  always #5 clk = ~clk;

  reg_file32 #(
    .WIDTH (W),
    .BYPASS(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .WriteEn    (WriteEn),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ErrClr     (ErrClr),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .MultiHotErr(MultiHotErr),
    .WriteCount (WriteCount)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  // Expected combinational read with the bypass rule applied to the current inputs.
  function automatic logic [W-1:0] exp_read(input logic [4:0] a);
    if (reset || a == 5'd0) return '0;
    if ($countones(WriteEn[31:1]) == 1 && WriteEn[a]) return WriteData;
    return m_regs[a];
  endfunction

  // Apply the effect of the edge just taken, using inputs that are still held.
  task automatic model_edge();
    int n;
    if (reset) begin
      model_reset();
      return;
    end
    n = $countones(WriteEn[31:1]);
    if (n == 1) begin
      for (int i = 1; i < 32; i++) if (WriteEn[i]) m_regs[i] = WriteData;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    if (n > 1) m_err = 1'b1;
    else if (ErrClr) m_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    WriteEn   = '0;
    WriteData = '0;
    ErrClr    = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    reset = 1'b1;
    idle();
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd31;
    model_reset();
    #12;
    e = exp_q.size() == 0 ? '0 : '0;
    if (ReadData1 !== 32'h0) begin
      $display("FAIL reset_rd1 got=%h exp=%h", ReadData1, 32'h0); mismatched++;
    end
    compared++;
    if (ReadData2 !== 32'h0) begin
      $display("FAIL reset_rd2 got=%h exp=%h", ReadData2, 32'h0); mismatched++;
    end
    compared++;
    if (MultiHotErr !== 1'b0) begin
      $display("FAIL reset_err got=%b exp=0", MultiHotErr); mismatched++;
    end
    compared++;
    if (WriteCount !== 16'd0) begin
      $display("FAIL reset_cnt got=%0d exp=0", WriteCount); mismatched++;
    end
    compared++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    exp_q.push_back(exp_read(5'd5));
    exp_q.push_back(exp_read(5'd31));
    #2;
    e = exp_q.pop_front();
    if (ReadData1 !== e) begin
      $display("FAIL post_reset_rd1 got=%h exp=%h", ReadData1, e); mismatched++;
    end
    compared++;
    e = exp_q.pop_front();
    if (ReadData2 !== e) begin
      $display("FAIL post_reset_rd2 got=%h exp=%h", ReadData2, e); mismatched++;
    end
    compared++;
  endtask

  task automatic test_write_read();
    logic [W-1:0] e;
    WriteEn   = 32'h0000_0008;
    WriteData = 32'hDEAD_BEEF;
    ReadReg1  = 5'd3;
    exp_q.push_back(exp_read(5'd3));
    #2;
    e = exp_q.pop_front();
    if (ReadData1 !== e) begin
      $display("FAIL wr_bypass_r3 got=%h exp=%h", ReadData1, e); mismatched++;
    end
    compared++;
    tick();
    idle();
    exp_q.push_back(exp_read(5'd3));
    #2;
    e = exp_q.pop_front();
    if (ReadData1 !== e) begin
      $display("FAIL wr_stored_r3 got=%h exp=%h", ReadData1, e); mismatched++;
    end
    compared++;
    if (WriteCount !== 16'd1) begin
      $display("FAIL wr_count got=%0d exp=1", WriteCount); mismatched++;
    end
    compared++;
  endtask

  task automatic test_r0();
    WriteEn   = 32'h0000_0001;
    WriteData = 32'hFFFF_FFFF;
    ReadReg1  = 5'd0;
    ReadReg2  = 5'd3;
    #2;
    if (ReadData1 !== 32'h0) begin
      $display("FAIL r0_before got=%h exp=0", ReadData1); mismatched++;
    end
    compared++;
    if (ReadData2 !== m_regs[3]) begin
      $display("FAIL r0_no_bypass_r3 got=%h exp=%h", ReadData2, m_regs[3]); mismatched++;
    end
    compared++;
    tick();
    #1;
    if (ReadData1 !== 32'h0) begin
      $display("FAIL r0_after got=%h exp=0", ReadData1); mismatched++;
    end
    compared++;
    if (WriteCount !== m_cnt) begin
      $display("FAIL r0_count got=%0d exp=%0d", WriteCount, m_cnt); mismatched++;
    end
    compared++;
    // WriteEn[0] is ignored, so 0x3 is a legal one-hot write to r1.
    WriteEn   = 32'h0000_0003;
    WriteData = 32'h0000_0111;
    tick();
    idle();
    ReadReg1 = 5'd1;
    #1;
    if (ReadData1 !== 32'h0000_0111 || WriteCount !== m_cnt || MultiHotErr !== 1'b0) begin
      $display("FAIL bit0_ignored got=%h/%0d/%b exp=%h/%0d/0", ReadData1, WriteCount,
               MultiHotErr, 32'h0000_0111, m_cnt);
      mismatched++;
    end
    compared++;
    idle();
  endtask

  task automatic test_multihot();
    logic [15:0] cnt0;
    WriteEn = 32'h0000_0010; WriteData = 32'h44; tick();
    WriteEn = 32'h0000_0020; WriteData = 32'h55; tick();
    cnt0 = m_cnt;
    WriteEn   = 32'h0000_0030;
    WriteData = 32'h1234;
    ReadReg1  = 5'd4;
    ReadReg2  = 5'd5;
    #2;
    if (ReadData1 !== 32'h44 || ReadData2 !== 32'h55) begin
      $display("FAIL mh_no_bypass got=%h,%h exp=44,55", ReadData1, ReadData2); mismatched++;
    end
    compared++;
    tick();
    idle();
    #1;
    if (ReadData1 !== 32'h44 || ReadData2 !== 32'h55) begin
      $display("FAIL mh_regs_kept got=%h,%h exp=44,55", ReadData1, ReadData2); mismatched++;
    end
    compared++;
    if (MultiHotErr !== 1'b1) begin
      $display("FAIL mh_err_set got=%b exp=1", MultiHotErr); mismatched++;
    end
    compared++;
    if (WriteCount !== cnt0) begin
      $display("FAIL mh_count_hold got=%0d exp=%0d", WriteCount, cnt0); mismatched++;
    end
    compared++;
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    #1;
    if (MultiHotErr !== 1'b0) begin
      $display("FAIL mh_err_clr got=%b exp=0", MultiHotErr); mismatched++;
    end
    compared++;
    // Set and clear at the same edge: set wins.
    WriteEn = 32'h8000_0002;
    ErrClr  = 1'b1;
    tick();
    idle();
    #1;
    if (MultiHotErr !== m_err || m_err !== 1'b1) begin
      $display("FAIL mh_set_wins got=%b exp=1", MultiHotErr); mismatched++;
    end
    compared++;
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
  endtask

  task automatic test_bypass();
    WriteEn   = 32'h0000_0080;
    WriteData = 32'hA5A5_A5A5;
    ReadReg1  = 5'd7;
    ReadReg2  = 5'd7;
    #2;
    if (ReadData1 !== 32'hA5A5_A5A5 || ReadData2 !== 32'hA5A5_A5A5) begin
      $display("FAIL bypass_r7 got=%h,%h exp=a5a5a5a5", ReadData1, ReadData2); mismatched++;
    end
    compared++;
    tick();
    idle();
    #1;
    if (ReadData1 !== m_regs[7] || ReadData2 !== m_regs[7]) begin
      $display("FAIL bypass_r7_stored got=%h,%h exp=%h", ReadData1, ReadData2, m_regs[7]);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    for (int i = 1; i < 32; i++) begin
      WriteEn   = 32'h1 << i;
      WriteData = $urandom();
      ReadReg1  = 5'(i);
      ReadReg2  = 5'(i - 1);
      exp_q.push_back(exp_read(ReadReg1));
      exp_q.push_back(exp_read(ReadReg2));
      #2;
      e = exp_q.pop_front();
      if (ReadData1 !== e) begin
        $display("FAIL b2b_rd1[%0d] got=%h exp=%h", i, ReadData1, e); mismatched++;
      end
      compared++;
      e = exp_q.pop_front();
      if (ReadData2 !== e) begin
        $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, ReadData2, e); mismatched++;
      end
      compared++;
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) exp_q.push_back(exp_read(5'(i)));
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(i);
      #1;
      e = exp_q.pop_front();
      if (ReadData1 !== e || ReadData2 !== e) begin
        $display("FAIL readback[%0d] got=%h,%h exp=%h", i, ReadData1, ReadData2, e);
        mismatched++;
      end
      compared++;
    end
  endtask

  task automatic test_async_reset();
    WriteEn = 32'h1 << 9; WriteData = 32'h55; tick();
    idle();
    ReadReg1 = 5'd9;
    #1;
    if (ReadData1 !== 32'h55) begin
      $display("FAIL ar_pre got=%h exp=55", ReadData1); mismatched++;
    end
    compared++;
    // Pending write in flight when reset hits between edges.
    WriteEn   = 32'h1 << 9;
    WriteData = 32'h77;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    if (ReadData1 !== 32'h0 || WriteCount !== 16'd0 || MultiHotErr !== 1'b0) begin
      $display("FAIL ar_immediate got=%h/%0d/%b exp=0/0/0", ReadData1, WriteCount, MultiHotErr);
      mismatched++;
    end
    compared++;
    tick();
    #1;
    reset = 1'b0;
    WriteData = 32'h99;
    #1;
    if (ReadData1 !== 32'h99) begin
      $display("FAIL ar_bypass_after got=%h exp=99", ReadData1); mismatched++;
    end
    compared++;
    tick();
    idle();
    #1;
    if (ReadData1 !== 32'h99 || WriteCount !== 16'd1) begin
      $display("FAIL ar_first_write got=%h/%0d exp=99/1", ReadData1, WriteCount); mismatched++;
    end
    compared++;
  endtask

  task automatic test_saturate();
    WriteEn   = 32'h0000_0004;
    WriteData = 32'h2;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFE; i++) tick();
    if (WriteCount !== 16'hFFFE) begin
      $display("FAIL sat_fffe got=%h exp=fffe", WriteCount); mismatched++;
    end
    compared++;
    repeat (3) tick();
    if (WriteCount !== 16'hFFFF) begin
      $display("FAIL sat_hold got=%h exp=ffff", WriteCount); mismatched++;
    end
    compared++;
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_multihot();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      mismatched++;
    end
    compared++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
